// File: rtl/instr_sequencer.sv
// Instruction sequencer: fetch -> decode -> dispatch to one of three execution FSMs,
// waits for the selected unit's done, and traps undefined opcodes and hung units.
module instr_sequencer #(
    parameter int IW      = 16,
    parameter int PW      = 6,
    parameter int TIMEOUT = 16,
    parameter int CNTW    = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            run,
    output logic            fetch_start,
    input  logic            fetch_done,
    input  logic [IW-1:0]   instr,
    output logic [PW-1:0]   parameter1,
    output logic [PW-1:0]   parameter2,
    output logic            imm_start,
    input  logic            imm_done,
    output logic            reg_start,
    input  logic            reg_done,
    output logic            mov_start,
    input  logic            mov_done,
    output logic            busy,
    output logic            halted,
    output logic            illegal,
    output logic            timeout_err,
    output logic [CNTW-1:0] instr_count
);

    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    // Last WAIT cycle that may still see done; the next one is already ERR.
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 2);

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_IMM  = 4'h1;
    localparam logic [3:0] OP_REG  = 4'h2;
    localparam logic [3:0] OP_MOV  = 4'h3;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_FWAIT,
        S_DECODE,
        S_EXEC,
        S_WAIT,
        S_RETIRE,
        S_HALT,
        S_ERR
    } state_t;

    state_t          state, state_nxt;
    logic [3:0]      opcode;
    logic [TW-1:0]   timer;
    logic            err_ill, err_to;
    logic            sel_done;

    // Only the unit that was started may end the WAIT.
    always_comb begin
        sel_done = 1'b0;
        case (opcode)
            OP_IMM:  sel_done = imm_done;
            OP_REG:  sel_done = reg_done;
            OP_MOV:  sel_done = mov_done;
            default: sel_done = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (run) state_nxt = S_FETCH;
            S_FETCH:  state_nxt = S_FWAIT;
            S_FWAIT:  if (fetch_done) state_nxt = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_NOP:                 state_nxt = S_RETIRE;
                    OP_IMM, OP_REG, OP_MOV: state_nxt = S_EXEC;
                    OP_HALT:                state_nxt = S_HALT;
                    default:                state_nxt = S_ERR;
                endcase
            end
            S_EXEC:   state_nxt = S_WAIT;
            S_WAIT: begin
                if (sel_done)            state_nxt = S_RETIRE;
                else if (timer == T_LAST) state_nxt = S_ERR;
            end
            S_RETIRE: state_nxt = run ? S_FETCH : S_IDLE;
            S_HALT:   if (!run) state_nxt = S_IDLE;
            S_ERR:    if (!run) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        fetch_start = 1'b0;
        imm_start   = 1'b0;
        reg_start   = 1'b0;
        mov_start   = 1'b0;
        busy        = 1'b0;
        halted      = 1'b0;
        case (state)
            S_IDLE, S_ERR: ;
            S_HALT:  halted = 1'b1;
            S_FETCH: begin
                fetch_start = 1'b1;
                busy        = 1'b1;
            end
            S_EXEC: begin
                imm_start = (opcode == OP_IMM);
                reg_start = (opcode == OP_REG);
                mov_start = (opcode == OP_MOV);
                busy      = 1'b1;
            end
            default: busy = 1'b1;
        endcase
    end

    assign illegal     = err_ill;
    assign timeout_err = err_to;

    // Operand fields load only on an accepted fetch and then hold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            opcode     <= '0;
            parameter1 <= '0;
            parameter2 <= '0;
        end else if (state == S_FWAIT && fetch_done) begin
            opcode     <= instr[IW-1:IW-4];
            parameter1 <= instr[2*PW-1:PW];
            parameter2 <= instr[PW-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timer <= '0;
        end else if (state == S_EXEC) begin
            timer <= '0;
        end else if (state == S_WAIT && !sel_done) begin
            timer <= timer + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instr_count <= '0;
        end else if (state == S_RETIRE) begin
            instr_count <= instr_count + 1'b1;
        end
    end

    // Error cause flags live exactly as long as the ERR state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_ill <= 1'b0;
            err_to  <= 1'b0;
        end else if (state == S_DECODE && state_nxt == S_ERR) begin
            err_ill <= 1'b1;
        end else if (state == S_WAIT && state_nxt == S_ERR) begin
            err_to  <= 1'b1;
        end else if (state == S_ERR && !run) begin
            err_ill <= 1'b0;
            err_to  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: NOP latency, unit dispatch, done filtering,
// timeout, illegal opcode, halt, counter wrap and asynchronous reset in WAIT.
module tb_instr_sequencer;

    localparam int IW = 16, PW = 6, TIMEOUT = 16, CNTW = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            run = 1'b0;
    logic            fetch_start, fetch_done = 1'b0;
    logic [IW-1:0]   instr = '0;
    logic [PW-1:0]   parameter1, parameter2;
    logic            imm_start, reg_start, mov_start;
    logic            imm_done = 1'b0, reg_done = 1'b0, mov_done = 1'b0;
    logic            busy, halted, illegal, timeout_err;
    logic [CNTW-1:0] instr_count;

    int n_chk  = 0;
    int n_pass = 0;

    instr_sequencer #(.IW(IW), .PW(PW), .TIMEOUT(TIMEOUT), .CNTW(CNTW)) dut (
        .clk(clk), .rst(rst), .run(run),
        .fetch_start(fetch_start), .fetch_done(fetch_done), .instr(instr),
        .parameter1(parameter1), .parameter2(parameter2),
        .imm_start(imm_start), .imm_done(imm_done),
        .reg_start(reg_start), .reg_done(reg_done),
        .mov_start(mov_start), .mov_done(mov_done),
        .busy(busy), .halted(halted), .illegal(illegal), .timeout_err(timeout_err),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_fetch(input string tag);
        int k;
        k = 0;
        while (!fetch_start && k < 10) begin
            step();
            k++;
        end
        chk(tag, {31'd0, fetch_start}, 32'd1);
    endtask

    // Called in the FETCH cycle; returns in the DECODE cycle.
    task automatic issue(input logic [IW-1:0] w);
        step();
        fetch_done = 1'b1;
        instr      = w;
        step();
        fetch_done = 1'b0;
        instr      = '0;
    endtask

    function automatic logic [2:0] starts();
        return {imm_start, reg_start, mov_start};
    endfunction

    initial begin
        // reset state
        #12;
        chk("rst_busy",  {31'd0, busy}, 0);
        chk("rst_fetch", {31'd0, fetch_start}, 0);
        chk("rst_flags", {29'd0, halted, illegal, timeout_err}, 0);
        chk("rst_cnt",   {24'd0, instr_count}, 0);
        chk("rst_par",   {20'd0, parameter1, parameter2}, 0);
        @(negedge clk);
        rst = 1'b1;
        run = 1'b1;

        // 1: NOP, FETCH -> FETCH in 4 cycles
        wait_fetch("t1_fetch0");
        issue(16'h0000);
        chk("t1_dec_fs", {31'd0, fetch_start}, 0);
        step();
        chk("t1_ret_fs", {31'd0, fetch_start}, 0);
        step();
        chk("t1_fs4",  {31'd0, fetch_start}, 1);
        chk("t1_cnt",  {24'd0, instr_count}, 1);

        // 2: ALU-immediate, done 3 cycles after start
        issue(16'h10C5);
        chk("t2_dec_st", {29'd0, starts()}, 0);
        step();
        chk("t2_exec_st", {29'd0, starts()}, 3'b100);
        chk("t2_exec_fs", {31'd0, fetch_start}, 0);
        chk("t2_p1", {26'd0, parameter1}, 6'h03);
        chk("t2_p2", {26'd0, parameter2}, 6'h05);
        step();
        chk("t2_w1_st", {29'd0, starts()}, 0);
        step();
        step();
        imm_done = 1'b1;
        chk("t2_w3_busy", {31'd0, busy}, 1);
        chk("t2_w3_par", {20'd0, parameter1, parameter2}, {20'd0, 6'h03, 6'h05});
        step();
        imm_done = 1'b0;
        chk("t2_ret_cnt", {24'd0, instr_count}, 1);
        step();
        chk("t2_fs",  {31'd0, fetch_start}, 1);
        chk("t2_cnt", {24'd0, instr_count}, 2);
        chk("t2_par", {20'd0, parameter1, parameter2}, {20'd0, 6'h03, 6'h05});

        // 3: reg-reg, foreign dones ignored
        issue(16'h2041);
        step();
        chk("t3_exec_st", {29'd0, starts()}, 3'b010);
        step();
        mov_done = 1'b1;
        imm_done = 1'b1;
        step();
        mov_done = 1'b0;
        imm_done = 1'b0;
        chk("t3_w2_busy", {31'd0, busy}, 1);
        chk("t3_w2_st", {29'd0, starts()}, 0);
        reg_done = 1'b1;
        step();
        reg_done = 1'b0;
        chk("t3_ret_fs",  {31'd0, fetch_start}, 0);
        chk("t3_ret_cnt", {24'd0, instr_count}, 2);
        step();
        chk("t3_fs",  {31'd0, fetch_start}, 1);
        chk("t3_cnt", {24'd0, instr_count}, 3);

        // 4: MOV never completes -> timeout on the 16th cycle after start
        issue(16'h3000);
        step();
        chk("t4_exec_st", {29'd0, starts()}, 3'b001);
        for (int i = 1; i < TIMEOUT; i++) step();
        chk("t4_w15_to",   {31'd0, timeout_err}, 0);
        chk("t4_w15_busy", {31'd0, busy}, 1);
        step();
        chk("t4_to",   {31'd0, timeout_err}, 1);
        chk("t4_busy", {31'd0, busy}, 0);
        chk("t4_ill",  {31'd0, illegal}, 0);
        chk("t4_cnt",  {24'd0, instr_count}, 3);
        step();
        chk("t4_hold", {31'd0, timeout_err}, 1);
        run = 1'b0;
        step();
        chk("t4_clr", {31'd0, timeout_err}, 0);
        chk("t4_idle_busy", {31'd0, busy}, 0);

        // 5: illegal opcode, then HALT
        run = 1'b1;
        wait_fetch("t5_fetch");
        issue(16'h7000);
        step();
        chk("t5_ill",  {31'd0, illegal}, 1);
        chk("t5_st",   {29'd0, starts()}, 0);
        chk("t5_busy", {31'd0, busy}, 0);
        chk("t5_to",   {31'd0, timeout_err}, 0);
        step();
        chk("t5_hold", {31'd0, illegal}, 1);
        chk("t5_fs",   {31'd0, fetch_start}, 0);
        run = 1'b0;
        step();
        chk("t5_clr", {31'd0, illegal}, 0);
        run = 1'b1;
        wait_fetch("t5_fetch2");
        issue(16'hF000);
        step();
        chk("t5_halt", {31'd0, halted}, 1);
        chk("t5_hbusy", {31'd0, busy}, 0);
        step();
        step();
        chk("t5_hhold", {31'd0, halted}, 1);
        chk("t5_hcnt", {24'd0, instr_count}, 3);
        run = 1'b0;
        step();
        chk("t5_unhalt", {31'd0, halted}, 0);

        // 6: counter wrap, then reset while in WAIT
        run = 1'b1;
        wait_fetch("t6_fetch");
        for (int i = 0; i < 252; i++) begin
            issue(16'h0000);
            step();
            step();
        end
        chk("t6_max", {24'd0, instr_count}, 32'hFF);
        issue(16'h0000);
        step();
        step();
        chk("t6_wrap", {24'd0, instr_count}, 0);
        issue(16'h1041);
        step();
        step();
        chk("t6_wbusy", {31'd0, busy}, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("t6_rbusy", {31'd0, busy}, 0);
        chk("t6_rst",   {29'd0, starts()}, 0);
        chk("t6_rfs",   {31'd0, fetch_start}, 0);
        chk("t6_rpar",  {20'd0, parameter1, parameter2}, 0);
        chk("t6_rflag", {29'd0, halted, illegal, timeout_err}, 0);
        step();
        chk("t6_rhold", {31'd0, busy}, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
